// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: fetches from instruction memory, holds the
// instruction for execution, resolves branches/jumps and tracks retired instructions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  BrOp,
  input  logic [31:0] RURs1,
  input  logic [31:0] RURs2,
  input  logic [31:0] ALURes,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Inst,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] PCInc,
  output logic [31:0] retire_cnt,
  output logic [1:0]  err
);

  localparam int unsigned TmoW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(IMEM_TIMEOUT - 1);
  localparam logic [31:0] NopInst = 32'h0000_0013;

  localparam logic [1:0] ErrNone       = 2'b00;
  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrTimeout    = 2'b10;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     retire_q, retire_d;
  logic [1:0]      err_q, err_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        eq, lt_s, lt_u;
  logic        cond;
  logic        taken;

  assign pc_inc = pc_q + 32'd4;
  assign target = {ALURes[31:1], 1'b0};
  assign eq     = (RURs1 == RURs2);
  assign lt_s   = ($signed(RURs1) < $signed(RURs2));
  assign lt_u   = (RURs1 < RURs2);

  always_comb begin
    cond = 1'b0;
    case (BrOp[2:0])
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  // BrOp[4] is an unconditional jump and overrides the conditional-branch bits.
  assign taken = BrOp[4] | (BrOp[3] & cond);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    retire_d = retire_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StIdle: begin
        tmo_d   = '0;
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          inst_d  = imem_rdata;
          tmo_d   = '0;
          state_d = StExec;
        end else if (tmo_q == TmoLast) begin
          if (err_q == ErrNone) err_d = ErrTimeout;
          state_d = StHalt;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StExec: begin
        if (!hold) begin
          if (taken && target[1]) begin
            if (err_q == ErrNone) err_d = ErrMisaligned;
            state_d = StHalt;
          end else begin
            pc_d     = taken ? target : pc_inc;
            retire_d = retire_q + 32'd1;
            state_d  = StFetch;
          end
        end
      end
      StHalt: begin
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      inst_q   <= NopInst;
      retire_q <= '0;
      err_q    <= ErrNone;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      retire_q <= retire_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign imem_req   = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == StExec);
  assign Inst       = inst_q;
  assign PC         = pc_q;
  assign PCInc      = pc_inc;
  assign retire_cnt = retire_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a cycle-level reference model checked on every falling
// edge, plus hand-computed literal checks after each scenario.
module tb_pc_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int unsigned Tmo   = 16;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  BrOp = '0;
  logic [31:0] RURs1 = '0, RURs2 = '0, ALURes = '0;
  logic        hold = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Inst;
  logic        inst_valid;
  logic [31:0] PC, PCInc, retire_cnt;
  logic [1:0]  err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC     (RstPc),
    .IMEM_TIMEOUT (Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BrOp       (BrOp),
    .RURs1      (RURs1),
    .RURs2      (RURs2),
    .ALURes     (ALURes),
    .hold       (hold),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .Inst       (Inst),
    .inst_valid (inst_valid),
    .PC         (PC),
    .PCInc      (PCInc),
    .retire_cnt (retire_cnt),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the current instruction and architectural state.
  localparam int PIdle = 0, PFetch = 1, PExec = 2, PHalt = 3;
  int          m_phase;
  int          m_wait;
  logic [31:0] m_pc, m_inst, m_ret;
  logic [1:0]  m_err;

  function automatic bit br_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (op >= 5'd16) return 1'b1;
    if (op < 5'd8) return 1'b0;
    case (op - 5'd8)
      5'd0:    return a == b;
      5'd1:    return a != b;
      5'd4:    return sa < sb;
      5'd5:    return sa >= sb;
      5'd6:    return a < b;
      5'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PIdle;
      m_wait  <= 0;
      m_pc    <= RstPc;
      m_inst  <= Nop;
      m_ret   <= 0;
      m_err   <= 2'd0;
    end else begin
      case (m_phase)
        PIdle: begin
          m_phase <= PFetch;
          m_wait  <= 0;
        end
        PFetch: begin
          if (imem_valid) begin
            m_inst  <= imem_rdata;
            m_wait  <= 0;
            m_phase <= PExec;
          end else if (m_wait + 1 >= int'(Tmo)) begin
            if (m_err == 2'd0) m_err <= 2'd2;
            m_phase <= PHalt;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        PExec: begin
          if (!hold) begin
            if (br_taken(BrOp, RURs1, RURs2)) begin
              if ((ALURes - (ALURes % 2)) % 4 != 0) begin
                if (m_err == 2'd0) m_err <= 2'd1;
                m_phase <= PHalt;
              end else begin
                m_pc    <= ALURes - (ALURes % 2);
                m_ret   <= m_ret + 1;
                m_phase <= PFetch;
              end
            end else begin
              m_pc    <= m_pc + 4;
              m_ret   <= m_ret + 1;
              m_phase <= PFetch;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("model_imem_req", {31'd0, imem_req}, {31'd0, m_phase == PFetch});
    check("model_inst_valid", {31'd0, inst_valid}, {31'd0, m_phase == PExec});
    if (m_phase == PFetch) check("model_imem_addr", imem_addr, m_pc);
    check("model_pc", PC, m_pc);
    check("model_pcinc", PCInc, m_pc + 32'd4);
    check("model_inst", Inst, m_inst);
    check("model_retire", retire_cnt, m_ret);
    check("model_err", {30'd0, err}, {30'd0, m_err});
  end

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
  endtask

  task automatic instr(input logic [31:0] addr, input int lat, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                       input int holdn);
    BrOp   = op;
    RURs1  = a;
    RURs2  = b;
    ALURes = alu;
    wait_req(addr);
    repeat (lat) begin
      @(posedge clk);
      #1;
    end
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    check("exec_entered", {31'd0, inst_valid}, 32'd1);
    if (holdn > 0) begin
      hold = 1'b1;
      repeat (holdn) @(posedge clk);
      #1;
      hold = 1'b0;
    end
    check("pc_held", PC, addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", PC, 32'h0);
    check("rst_inst", Inst, 32'h13);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;

    instr(32'h0, 1, 5'b00000, 0, 0, 0, 0);
    instr(32'h4, 1, 5'b00000, 0, 0, 0, 0);
    instr(32'h8, 1, 5'b00000, 0, 0, 0, 0);
    check("seq_retire", retire_cnt, 32'd3);
    check("seq_pc", PC, 32'hC);

    instr(32'hC, 0, 5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h40, 0);
    check("blt_pc", PC, 32'h40);
    instr(32'h40, 0, 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h40, 0);
    check("bltu_pc", PC, 32'h44);
    instr(32'h44, 0, 5'b01000, 32'd7, 32'd7, 32'h40, 0);
    check("beq_pc", PC, 32'h40);
    instr(32'h40, 2, 5'b01001, 32'd7, 32'd7, 32'h80, 0);
    instr(32'h44, 0, 5'b01111, 32'hFFFF_FFFF, 32'd1, 32'h80, 0);
    check("bgeu_pc", PC, 32'h80);
    instr(32'h80, 0, 5'b01101, 32'hFFFF_FFFF, 32'd1, 32'h200, 0);
    instr(32'h84, 0, 5'b01010, 32'd3, 32'd3, 32'h200, 0);
    instr(32'h88, 0, 5'b00111, 32'hFFFF_FFFF, 32'd1, 32'h200, 0);
    check("notbranch_pc", PC, 32'h8C);

    instr(32'h8C, 1, 5'b00000, 0, 0, 0, 5);
    check("hold_pc", PC, 32'h90);

    instr(32'h90, 0, 5'b10000, 0, 0, 32'h101, 0);
    check("jalr_pc", PC, 32'h100);
    instr(32'h100, 0, 5'b11001, 32'd7, 32'd7, 32'h201, 0);
    check("jump_priority_pc", PC, 32'h200);

    instr(32'h200, 0, 5'b10000, 0, 0, 32'hFFFF_FFFD, 0);
    check("pre_wrap_pc", PC, 32'hFFFF_FFFC);
    instr(32'hFFFF_FFFC, 0, 5'b00000, 0, 0, 0, 0);
    check("wrap_pc", PC, 32'h0);
    check("wrap_err", {30'd0, err}, 32'd0);
    check("wrap_retire", retire_cnt, 32'd16);

    instr(32'h0, 0, 5'b10000, 0, 0, 32'h102, 0);
    check("misalign_err", {30'd0, err}, 32'd1);
    check("misalign_pc", PC, 32'h0);
    check("misalign_retire", retire_cnt, 32'd16);
    imem_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    imem_valid = 1'b0;
    check("halt_req", {31'd0, imem_req}, 32'd0);
    check("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("halt_err_sticky", {30'd0, err}, 32'd1);

    rst_n = 1'b0;
    #3;
    check("rst2_err", {30'd0, err}, 32'd0);
    rst_n = 1'b1;
    instr(32'h0, 15, 5'b00000, 0, 0, 0, 0);
    check("tmo_edge_err", {30'd0, err}, 32'd0);
    check("tmo_edge_pc", PC, 32'h4);
    wait_req(32'h4);
    repeat (20) @(posedge clk);
    #1;
    check("tmo_err", {30'd0, err}, 32'd2);
    check("tmo_req", {31'd0, imem_req}, 32'd0);
    check("tmo_pc", PC, 32'h4);

    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    instr(32'h0, 0, 5'b00000, 0, 0, 0, 0);
    instr(32'h4, 0, 5'b00000, 0, 0, 0, 0);
    wait_req(32'h8);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    check("rstfetch_inst", Inst, 32'h13);
    check("rstfetch_pc", PC, 32'h0);
    check("rstfetch_retire", retire_cnt, 32'd0);
    #2;
    rst_n = 1'b1;
    instr(32'h0, 1, 5'b00000, 0, 0, 0, 0);
    check("post_rst_pc", PC, 32'h4);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL take parameter IMEM_TIMEOUT, default 16: maximum FETCH wait cycles before an error.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port BrOp, input, 5 bits: branch operation from the control unit.
REQ-006 The block SHALL have ports RURs1 and RURs2, input, 32 bits each: register-file operands for branch compare.
REQ-007 The block SHALL have port ALURes, input, 32 bits: jump/branch target computed by the ALU.
REQ-008 The block SHALL have port hold, input, 1 bit: freezes the EXEC state while high.
REQ-009 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: instruction memory address.
REQ-011 The block SHALL have port imem_valid, input, 1 bit: instruction memory data valid.
REQ-012 The block SHALL have port imem_rdata, input, 32 bits: instruction memory read data.
REQ-013 The block SHALL have port Inst, output, 32 bits: latched instruction to decode.
REQ-014 The block SHALL have port inst_valid, output, 1 bit: high while Inst is being executed.
REQ-015 The block SHALL have ports PC and PCInc, output, 32 bits each: current PC and PC+4.
REQ-016 The block SHALL have port retire_cnt, output, 32 bits: count of retired instructions.
REQ-017 The block SHALL have port err, output, 2 bits: sticky error code; 00 none, 01 misaligned target, 10 fetch timeout.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC and HALT; reset enters IDLE; IDLE->FETCH unconditionally after 1 cycle.
REQ-019 In FETCH, imem_req=1 and imem_addr=PC; on imem_valid=1, Inst<=imem_rdata and the FSM goes to EXEC the next cycle.
REQ-020 FETCH SHALL count wait cycles; if IMEM_TIMEOUT cycles elapse without imem_valid, err<=10 and the FSM goes to HALT.
REQ-021 In EXEC, inst_valid=1 and imem_req=0; while hold=1 the block SHALL stay in EXEC with PC, Inst and retire_cnt unchanged.
REQ-022 In EXEC with hold=0, taken SHALL equal BrOp[4] | (BrOp[3] & cond); cond SHALL be selected by BrOp[2:0]: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge, 010/011 zero.
REQ-023 BrOp[4] SHALL take priority over BrOp[3:0]; BrOp=00xxx SHALL be not-taken.
REQ-024 The target SHALL be {ALURes[31:1],1'b0}; next PC SHALL be target if taken, else PC+4; 32-bit arithmetic SHALL wrap modulo 2^32 (0xFFFFFFFC+4=0).
REQ-025 If taken and target[1]=1, the block SHALL set err<=01, leave PC unchanged, not increment retire_cnt, and go to HALT.
REQ-026 Otherwise, on the EXEC->FETCH edge, PC<=next PC and retire_cnt<=retire_cnt+1 (wrapping at 2^32).
REQ-027 PCInc SHALL be combinationally PC+4 in all states.
REQ-028 HALT SHALL be absorbing until reset; imem_req=0 and inst_valid=0 in HALT; err SHALL hold its first nonzero value.
REQ-029 imem_valid SHALL be ignored outside FETCH.

Reset
REQ-030 On rst_n=0, immediately and regardless of state, the block SHALL set: state IDLE; PC=RESET_PC; Inst=32'h00000013 (nop); inst_valid=0; imem_req=0; retire_cnt=0; err=00; timeout counter=0.
REQ-031 Reset asserted mid-FETCH or mid-EXEC SHALL abort the access with no PC/retire_cnt update; after deassertion the first request SHALL be to RESET_PC.

Verification
REQ-032 Sequential flow: imem_valid 1 cycle after each req, BrOp=00000 for 3 instructions -> addresses 0,4,8; retire_cnt=3; inst_valid high 1 cycle per instruction.
REQ-033 Branches: RURs1=-1, RURs2=1, ALURes=0x40: BrOp=01100 (blt) -> PC=0x40; BrOp=01110 (bltu) -> PC=old+4; BrOp=01000 with equal operands -> PC=0x40.
REQ-034 jalr alignment: BrOp=10000, ALURes=0x101 -> PC=0x100; ALURes=0x102 -> err=01, HALT, PC and retire_cnt unchanged.
REQ-035 Hold and timeout: hold=1 for 5 EXEC cycles -> no PC change, then advance; imem_valid withheld 16 cycles -> err=10, imem_req=0.
REQ-036 Reset during FETCH with imem_valid arriving in the same cycle -> Inst=nop, PC=RESET_PC, retire_cnt=0.
REQ-037 Wrap: PC=0xFFFFFFFC, not-taken -> next PC=0x00000000, no error.
